// File: rtl/kypd_key_emulator.sv
// Emulates one pressed key of a 4x4 active-low keypad: a queued key code runs a
// bounce / hold / release sequence and pulls the mapped row low while its column is strobed.
module kypd_key_emulator #(
  parameter int HOLD_CYCLES    = 2000000,
  parameter int RELEASE_CYCLES = 1000000,
  parameter int BOUNCE_CYCLES  = 100000,
  parameter int BOUNCE_LOG2    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       pressed,
  output logic [1:0] dbg_state
);

  // Handshake: a press is taken on any clk edge where key_valid && key_ready;
  // key_ready is high only in IDLE, so requests during a press are simply not taken.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BOUNCE  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic        BOUNCE_EN    = (BOUNCE_CYCLES > 0);
  localparam logic        RELEASE_EN   = (RELEASE_CYCLES > 0);
  localparam logic [23:0] BOUNCE_LAST  = 24'(BOUNCE_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST    = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] RELEASE_LAST = 24'(RELEASE_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [23:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_key, w_key_nxt;
  logic        r_pressed, w_pressed_nxt;
  logic [1:0]  w_key_row, w_key_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_key     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_key     <= w_key_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  // cnt counts cycles already spent in the current phase; pressed is registered
  // alongside state so it changes on the same edge as the phase.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 24'd1;
    w_key_nxt     = r_key;
    w_pressed_nxt = r_pressed;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_pressed_nxt = 1'b0;
        if (key_valid) begin
          w_key_nxt     = key_code;
          w_state_nxt   = BOUNCE_EN ? S_BOUNCE : S_HOLD;
          w_pressed_nxt = 1'b1;
        end
      end
      S_BOUNCE: begin
        if (r_cnt == BOUNCE_LAST) begin
          w_state_nxt   = S_HOLD;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b1;
        end else begin
          w_pressed_nxt = ~w_cnt_nxt[BOUNCE_LOG2];
        end
      end
      S_HOLD: begin
        w_pressed_nxt = 1'b1;
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt   = RELEASE_EN ? S_RELEASE : S_IDLE;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b0;
        end
      end
      S_RELEASE: begin
        w_pressed_nxt = 1'b0;
        if (r_cnt == RELEASE_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_pressed_nxt = 1'b0;
      end
    endcase
  end

  // Key code to (row, col) position on the Pmod keypad.
  always_comb begin
    w_key_row = 2'd0;
    w_key_col = 2'd0;
    case (r_key)
      4'h1: begin w_key_row = 2'd3; w_key_col = 2'd3; end
      4'h2: begin w_key_row = 2'd3; w_key_col = 2'd2; end
      4'h3: begin w_key_row = 2'd3; w_key_col = 2'd1; end
      4'hA: begin w_key_row = 2'd3; w_key_col = 2'd0; end
      4'h4: begin w_key_row = 2'd2; w_key_col = 2'd3; end
      4'h5: begin w_key_row = 2'd2; w_key_col = 2'd2; end
      4'h6: begin w_key_row = 2'd2; w_key_col = 2'd1; end
      4'hB: begin w_key_row = 2'd2; w_key_col = 2'd0; end
      4'h7: begin w_key_row = 2'd1; w_key_col = 2'd3; end
      4'h8: begin w_key_row = 2'd1; w_key_col = 2'd2; end
      4'h9: begin w_key_row = 2'd1; w_key_col = 2'd1; end
      4'hC: begin w_key_row = 2'd1; w_key_col = 2'd0; end
      4'h0: begin w_key_row = 2'd0; w_key_col = 2'd3; end
      4'hF: begin w_key_row = 2'd0; w_key_col = 2'd2; end
      4'hE: begin w_key_row = 2'd0; w_key_col = 2'd1; end
      default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
    endcase
  end

  // Row is a live function of col so the scanner sees the key in the strobe cycle.
  always_comb begin
    key_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    pressed   = r_pressed;
    dbg_state = r_state;
    row       = 4'hF;
    if (r_pressed && !col[w_key_col]) row[w_key_row] = 1'b0;
  end

endmodule

// File: tb/tb_kypd_key_emulator.sv
// Directed bench for kypd_key_emulator using three instances with different timing parameters.
module tb_kypd_key_emulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {row, col} position of keys 0..F on the keypad.
  logic [3:0] key_rc [16] = '{
    4'b0011, 4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b1010, 4'b1001, 4'b0111,
    4'b0110, 4'b0101, 4'b1100, 4'b1000, 4'b0100, 4'b0000, 4'b0001, 4'b0010};

  // Instance a: HOLD=10 RELEASE=5 no bounce
  logic [3:0] a_code = '0, a_col = 4'hF, a_row;
  logic       a_valid = 1'b0, a_ready, a_busy, a_pressed;
  logic [1:0] a_dbg;
  // Instance b: BOUNCE=16 LOG2=2 HOLD=10 RELEASE=2
  logic [3:0] b_code = '0, b_col = 4'hF, b_row;
  logic       b_valid = 1'b0, b_ready, b_busy, b_pressed;
  logic [1:0] b_dbg;
  // Instance c: HOLD=3 RELEASE=0 no bounce
  logic [3:0] c_code = '0, c_col = 4'hF, c_row;
  logic       c_valid = 1'b0, c_ready, c_busy, c_pressed;
  logic [1:0] c_dbg;

  kypd_key_emulator #(.HOLD_CYCLES(10), .RELEASE_CYCLES(5), .BOUNCE_CYCLES(0), .BOUNCE_LOG2(2)) u_a (
    .clk(clk), .rst(rst), .key_code(a_code), .key_valid(a_valid), .key_ready(a_ready),
    .col(a_col), .row(a_row), .busy(a_busy), .pressed(a_pressed), .dbg_state(a_dbg));

  kypd_key_emulator #(.HOLD_CYCLES(10), .RELEASE_CYCLES(2), .BOUNCE_CYCLES(16), .BOUNCE_LOG2(2)) u_b (
    .clk(clk), .rst(rst), .key_code(b_code), .key_valid(b_valid), .key_ready(b_ready),
    .col(b_col), .row(b_row), .busy(b_busy), .pressed(b_pressed), .dbg_state(b_dbg));

  kypd_key_emulator #(.HOLD_CYCLES(3), .RELEASE_CYCLES(0), .BOUNCE_CYCLES(0), .BOUNCE_LOG2(0)) u_c (
    .clk(clk), .rst(rst), .key_code(c_code), .key_valid(c_valid), .key_ready(c_ready),
    .col(c_col), .row(c_row), .busy(c_busy), .pressed(c_pressed), .dbg_state(c_dbg));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (a_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic press_a(input logic [3:0] code);
    a_code  = code;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; a_code = 4'h5; a_col = 4'h0;
    step(); step();
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed got=%b exp=0", a_pressed); end
    n_checks++; if (a_row !== 4'hF) begin n_fail++; $display("FAIL reset_row got=%b exp=1111", a_row); end
    n_checks++; if (a_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", a_dbg); end
    n_checks++; if (b_ready !== 1'b1 || c_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_bc got=%b%b exp=11", b_ready, c_ready);
    end
    rst = 1'b0; a_valid = 1'b0; a_col = 4'hF;
    step();
  endtask

  task automatic test_map_sweep();
    bit ok;
    logic [3:0] exp_row;
    logic [1:0] kr, kc;
    for (int k = 0; k < 16; k++) begin
      wait_ready_a(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL map_ready_timeout key=%0h", k); end
      press_a(4'(k));
      kr = key_rc[k][3:2];
      kc = key_rc[k][1:0];
      for (int c = 0; c < 4; c++) begin
        a_col = 4'hF ^ (4'b1000 >> c);
        exp_row = (kc == 2'(3 - c)) ? ~(4'b0001 << kr) : 4'hF;
        #1;
        n_checks++;
        if (a_row !== exp_row) begin
          n_fail++; $display("FAIL map key=%0h col=%b got_row=%b exp_row=%b", k, a_col, a_row, exp_row);
        end
      end
      a_col = 4'hF;
    end
  endtask

  task automatic test_handshake();
    bit ok;
    wait_ready_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hs_ready_timeout"); end
    a_code = 4'hA; a_valid = 1'b1; a_col = 4'h0;
    step();
    for (int n = 1; n <= 16; n++) begin
      n_checks++; if (a_pressed !== (n <= 10)) begin
        n_fail++; $display("FAIL hs_pressed n=%0d got=%b exp=%b", n, a_pressed, (n <= 10));
      end
      n_checks++; if (a_ready !== (n >= 16)) begin
        n_fail++; $display("FAIL hs_ready n=%0d got=%b exp=%b", n, a_ready, (n >= 16));
      end
      n_checks++; if (a_busy !== (n <= 15)) begin
        n_fail++; $display("FAIL hs_busy n=%0d got=%b exp=%b", n, a_busy, (n <= 15));
      end
      n_checks++; if (a_row !== ((n <= 10) ? 4'b0111 : 4'b1111)) begin
        n_fail++; $display("FAIL hs_row n=%0d got=%b exp=%b", n, a_row, ((n <= 10) ? 4'b0111 : 4'b1111));
      end
      step();
    end
    n_checks++; if (a_busy !== 1'b1 || a_pressed !== 1'b1) begin
      n_fail++; $display("FAIL hs_second_accept busy=%b pressed=%b exp=11", a_busy, a_pressed);
    end
    a_valid = 1'b0; a_col = 4'hF;
  endtask

  task automatic test_bounce();
    int edges;
    logic prev, exp_p;
    edges = 0; prev = 1'b0;
    b_code = 4'h5; b_valid = 1'b1; b_col = 4'b1011;
    step();
    b_valid = 1'b0;
    for (int n = 1; n <= 29; n++) begin
      exp_p = (n <= 16) ? (((n - 1) >> 2) % 2 == 0) : (n <= 26);
      n_checks++; if (b_pressed !== exp_p) begin
        n_fail++; $display("FAIL bounce_pressed n=%0d got=%b exp=%b", n, b_pressed, exp_p);
      end
      n_checks++; if (b_ready !== (n == 29)) begin
        n_fail++; $display("FAIL bounce_ready n=%0d got=%b exp=%b", n, b_ready, (n == 29));
      end
      n_checks++; if (b_row !== (exp_p ? 4'b1011 : 4'b1111)) begin
        n_fail++; $display("FAIL bounce_row n=%0d got=%b exp=%b", n, b_row, (exp_p ? 4'b1011 : 4'b1111));
      end
      if (n <= 16 && b_pressed !== prev) edges++;
      prev = b_pressed;
      if (n < 29) step();
    end
    n_checks++; if (edges != 4) begin n_fail++; $display("FAIL bounce_edges got=%0d exp=4", edges); end
    b_col = 4'hF;
  endtask

  task automatic test_release_zero();
    c_code = 4'h0; c_valid = 1'b1;
    step();
    c_code = 4'hF; c_col = 4'b0111;
    #1;
    n_checks++; if (c_row !== 4'b1110) begin n_fail++; $display("FAIL rz_row_key0 got=%b exp=1110", c_row); end
    step();
    c_col = 4'b1011;
    #1;
    n_checks++; if (c_row !== 4'b1111) begin n_fail++; $display("FAIL rz_code_change got=%b exp=1111", c_row); end
    step();
    n_checks++; if (c_pressed !== 1'b1 || c_ready !== 1'b0) begin
      n_fail++; $display("FAIL rz_hold_end pressed=%b ready=%b exp=10", c_pressed, c_ready);
    end
    step();
    n_checks++; if (c_ready !== 1'b1 || c_pressed !== 1'b0) begin
      n_fail++; $display("FAIL rz_ready_back ready=%b pressed=%b exp=10", c_ready, c_pressed);
    end
    step();
    n_checks++; if (c_busy !== 1'b1 || c_row !== 4'b1110) begin
      n_fail++; $display("FAIL rz_key_f busy=%b row=%b exp=1 1110", c_busy, c_row);
    end
    c_valid = 1'b0; c_col = 4'hF;
  endtask

  task automatic test_closed_loop();
    bit ok;
    logic [3:0] cl_keys [3] = '{4'h1, 4'h7, 4'hD};
    logic [4:0] decoded;
    logic [1:0] ri;
    for (int t = 0; t < 3; t++) begin
      wait_ready_a(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL cl_ready_timeout t=%0d", t); end
      press_a(cl_keys[t]);
      decoded = 5'h1F;
      for (int c = 0; c < 4; c++) begin
        a_col = 4'hF ^ (4'b1000 >> c);
        #1;
        if (a_row !== 4'hF) begin
          ri = 2'd0;
          for (int r = 0; r < 4; r++) if (a_row[r] === 1'b0) ri = 2'(r);
          for (int j = 0; j < 16; j++) if (key_rc[j] == {ri, 2'(3 - c)}) decoded = 5'(j);
        end
      end
      a_col = 4'hF;
      n_checks++; if (decoded !== {1'b0, cl_keys[t]}) begin
        n_fail++; $display("FAIL closed_loop t=%0d got=%h exp=%h", t, decoded, cl_keys[t]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    bit ok;
    int bad;
    wait_ready_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmh_ready_timeout"); end
    press_a(4'h5);
    a_col = 4'b1011;
    repeat (4) step();
    n_checks++; if (a_row !== 4'b1011) begin n_fail++; $display("FAIL rmh_row_before got=%b exp=1011", a_row); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (a_row !== 4'hF) begin n_fail++; $display("FAIL rmh_row got=%b exp=1111", a_row); end
    n_checks++; if (a_pressed !== 1'b0) begin n_fail++; $display("FAIL rmh_pressed got=%b exp=0", a_pressed); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rmh_ready got=%b exp=1", a_ready); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (a_row !== 4'hF || a_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rmh_quiet bad_cycles=%0d exp=0", bad); end
    a_col = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_map_sweep();
    test_handshake();
    test_bounce();
    test_release_zero();
    test_closed_loop();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
